// File: rtl/clk_rate_monitor.sv
// clk_rate_monitor
//   Checks a slow monitored clock (clk_in) against the system clock (clk).
//   clk_in is synchronized and its rising edges detected. The distance between
//   consecutive edges is measured in clk cycles and compared with an expected
//   period plus or minus a tolerance. Loss of clock is declared when no edge
//   arrives for LOSS_LIMIT cycles.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   clk_in       in   monitored slow clock, asynchronous to clk
//   enable       in   monitor enable, synchronous to clk
//   rise_pulse   out  one-cycle pulse per detected clk_in rising edge
//   period       out  last measured period in clk cycles (CNT_W bits)
//   period_valid out  one-cycle pulse when period updates
//   in_range     out  last period within EXP_PERIOD +/- TOL (inclusive)
//   clk_lost     out  no clk_in edge for LOSS_LIMIT cycles
`timescale 1ns/1ps

module clk_rate_monitor #(
  parameter int EXP_PERIOD = 5000,
  parameter int TOL        = 50,
  parameter int LOSS_LIMIT = 10000,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             clk_lost
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOST    = 2'd3
  } state_t;

  // Window bounds on CNT_W+1 bits so EXP_PERIOD+TOL cannot overflow the
  // comparison; the lower bound clamps at zero.
  localparam int             LO_INT   = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
  localparam int             HI_INT   = EXP_PERIOD + TOL;
  localparam logic [CNT_W:0] LO_BOUND = (CNT_W+1)'(LO_INT);
  localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(HI_INT);
  localparam logic [CNT_W-1:0] LOSS_CNT = CNT_W'(LOSS_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Input path: two-flop synchronizer, edge-history flop, registered edge pulse
  logic s1_reg, s2_reg, s3_reg, rise_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      s1_reg   <= clk_in;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      rise_reg <= s2_reg & ~s3_reg;
    end
  end

  // Measurement state
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             valid_reg, valid_next;
  logic             in_range_reg, in_range_next;
  logic             lost_reg, lost_next;

  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0]   cnt_ext;
  logic             in_window;
  logic             at_limit;

  // Saturating increment: a stuck counter must never wrap into a plausible value
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : (cnt_reg + CNT_ONE);
  assign cnt_ext   = {1'b0, cnt_reg};
  assign in_window = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);
  assign at_limit  = (cnt_reg >= LOSS_CNT);

  // State register (plus the registered datapath computed below)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      period_reg   <= '0;
      valid_reg    <= 1'b0;
      in_range_reg <= 1'b0;
      lost_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      period_reg   <= period_next;
      valid_reg    <= valid_next;
      in_range_reg <= in_range_next;
      lost_reg     <= lost_next;
    end
  end

  // Next-state logic. enable has priority over any edge; an edge has priority
  // over the loss limit in the same cycle.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = ARM;
        ARM:     if (rise_reg) state_next = MEASURE;
        MEASURE: if (!rise_reg && at_limit) state_next = LOST;
        LOST:    if (rise_reg) state_next = MEASURE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    cnt_next      = cnt_reg;
    period_next   = period_reg;
    valid_next    = 1'b0;
    in_range_next = in_range_reg;
    lost_next     = lost_reg;
    if (!enable) begin
      // period deliberately holds across a disable
      cnt_next      = '0;
      in_range_next = 1'b0;
      lost_next     = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
        end
        ARM: begin
          // first edge only opens the measurement window
          cnt_next = rise_reg ? CNT_ONE : cnt_inc;
        end
        MEASURE: begin
          if (rise_reg) begin
            period_next   = cnt_reg;
            valid_next    = 1'b1;
            in_range_next = in_window;
            cnt_next      = CNT_ONE;
          end else if (at_limit) begin
            lost_next     = 1'b1;
            in_range_next = 1'b0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        LOST: begin
          // the interval ending at the recovery edge is not a valid period
          if (rise_reg) begin
            lost_next = 1'b0;
            cnt_next  = CNT_ONE;
          end
        end
        default: begin
          cnt_next = '0;
        end
      endcase
    end
  end

  assign rise_pulse   = rise_reg;
  assign period       = period_reg;
  assign period_valid = valid_reg;
  assign in_range     = in_range_reg;
  assign clk_lost     = lost_reg;

endmodule

// File: tb/tb_clk_rate_monitor.sv
// tb_clk_rate_monitor
//   Directed bench for clk_rate_monitor with default parameters. clk_in is
//   driven on the falling edge of clk so edge spacing in clk cycles is exact.
//   Each vector places one clk_in rising edge a given number of cycles after
//   the previous one and states the expected outputs after it.
`timescale 1ns/1ps

module tb_clk_rate_monitor;

  localparam int CNT_W = 16;
  localparam int HIGH  = 20;   // clk_in high time in clk cycles

  logic             clk = 1'b0;
  logic             reset;
  logic             clk_in;
  logic             enable;
  logic             rise_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             in_range;
  logic             clk_lost;

  clk_rate_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .clk_in       (clk_in),
    .enable       (enable),
    .rise_pulse   (rise_pulse),
    .period       (period),
    .period_valid (period_valid),
    .in_range     (in_range),
    .clk_lost     (clk_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;      // cycles from previous clk_in rising edge
    bit valid;    // expect exactly one period_valid after this edge
    int per;      // expected period output
    bit ir;       // expected in_range output
    bit lost;     // expected clk_lost output
  } vec_t;

  typedef struct packed {
    logic [CNT_W-1:0] p;
    logic             ir;
  } pv_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_edge_cyc = 0;
  int  last_rise_cyc = 0;
  int  rise_cnt = 0;
  pv_t pv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (period_valid) pv_q.push_back('{p: period, ir: in_range});
    if (rise_pulse) begin
      rise_cnt      = rise_cnt + 1;
      last_rise_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int  rc0;
    pv_t item;
    while (cyc < last_edge_cyc + v.gap) @(negedge clk);
    rc0           = rise_cnt;
    clk_in        = 1'b1;
    last_edge_cyc = cyc;
    repeat (HIGH) @(negedge clk);
    clk_in = 1'b0;
    chk({tag, "_rise"}, rise_cnt - rc0, 1);
    if (v.valid) begin
      chk({tag, "_nvalid"}, pv_q.size(), 1);
      if (pv_q.size() > 0) begin
        item = pv_q.pop_front();
        chk({tag, "_vperiod"}, int'(item.p), v.per);
        chk({tag, "_vin_range"}, int'(item.ir), int'(v.ir));
      end
    end else begin
      chk({tag, "_nvalid"}, pv_q.size(), 0);
    end
    pv_q.delete();
    chk({tag, "_period"}, int'(period), v.per);
    chk({tag, "_in_range"}, int'(in_range), int'(v.ir));
    chk({tag, "_clk_lost"}, int'(clk_lost), int'(v.lost));
    $display("vec %s gap=%0d period=%0d in_range=%0d clk_lost=%0d", tag, v.gap,
             period, in_range, clk_lost);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rise"}, int'(rise_pulse), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(period_valid), 0);
    chk({tag, "_in_range"}, int'(in_range), 0);
    chk({tag, "_clk_lost"}, int'(clk_lost), 0);
  endtask

  // Global guard: the whole run is far below this
  initial begin
    #(95_000 * 10);
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   found;
    int   lost_at;

    // Nominal edges then both sides of the inclusive 4950..5050 window
    tbl[0] = '{gap: 50,   valid: 1'b0, per: 0,    ir: 1'b0, lost: 1'b0};
    tbl[1] = '{gap: 5000, valid: 1'b1, per: 5000, ir: 1'b1, lost: 1'b0};
    tbl[2] = '{gap: 5051, valid: 1'b1, per: 5051, ir: 1'b0, lost: 1'b0};
    tbl[3] = '{gap: 4949, valid: 1'b1, per: 4949, ir: 1'b0, lost: 1'b0};
    tbl[4] = '{gap: 4950, valid: 1'b1, per: 4950, ir: 1'b1, lost: 1'b0};
    tbl[5] = '{gap: 5050, valid: 1'b1, per: 5050, ir: 1'b1, lost: 1'b0};

    reset  = 1'b0;
    enable = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    reset         = 1'b1;
    enable        = 1'b1;
    last_edge_cyc = cyc;
    for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // clk_in stopped: loss declared 10000 cycles after rise_pulse drops
    found   = 0;
    lost_at = 0;
    for (int k = 0; k < 12000 && found == 0; k++) begin
      @(negedge clk);
      if (clk_lost) begin
        found   = 1;
        lost_at = cyc;
      end
    end
    chk("loss_seen", found, 1);
    chk("loss_delay", lost_at - last_rise_cyc, 10001);
    chk("loss_in_range", int'(in_range), 0);
    chk("loss_period", int'(period), 5050);
    chk("loss_nvalid", pv_q.size(), 0);
    $display("loss clk_lost=%0d after %0d cycles", clk_lost, lost_at - last_rise_cyc);

    // Recovery: first edge clears loss without a period, second measures
    apply_vec('{gap: 0,    valid: 1'b0, per: 5050, ir: 1'b0, lost: 1'b0}, "rec0");
    apply_vec('{gap: 5000, valid: 1'b1, per: 5000, ir: 1'b1, lost: 1'b0}, "rec1");

    // Disable mid-measurement; edges while disabled produce no period
    while (cyc < last_edge_cyc + 1000) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_in_range", int'(in_range), 0);
    chk("dis_clk_lost", int'(clk_lost), 0);
    chk("dis_period", int'(period), 5000);
    $display("disable period=%0d in_range=%0d", period, in_range);
    apply_vec('{gap: 1500, valid: 1'b0, per: 5000, ir: 1'b0, lost: 1'b0}, "dis0");
    apply_vec('{gap: 100,  valid: 1'b0, per: 5000, ir: 1'b0, lost: 1'b0}, "dis1");
    apply_vec('{gap: 100,  valid: 1'b0, per: 5000, ir: 1'b0, lost: 1'b0}, "dis2");
    enable = 1'b1;
    apply_vec('{gap: 300,  valid: 1'b0, per: 5000, ir: 1'b0, lost: 1'b0}, "ena0");
    apply_vec('{gap: 200,  valid: 1'b1, per: 200,  ir: 1'b0, lost: 1'b0}, "ena1");

    // Asynchronous reset mid-period clears outputs without waiting for clk
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("mid_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("post_reset");
    chk("post_reset_nvalid", pv_q.size(), 0);
    apply_vec('{gap: 50,   valid: 1'b0, per: 0,    ir: 1'b0, lost: 1'b0}, "rst0");
    apply_vec('{gap: 5000, valid: 1'b1, per: 5000, ir: 1'b1, lost: 1'b0}, "rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
